// File: rtl/ms6205_bus_arbiter.sv
// Round-robin arbiter sharing the MS6205 display write port between requesters.
// Each grant runs a two-phase transfer: address strobe, then data strobe.
// Each phase waits for the synchronized ready line, with a timeout.
module ms6205_bus_arbiter #(
   parameter int unsigned NUM_REQ       = 3,
   parameter int unsigned SETUP_CYCLES  = 2,
   parameter int unsigned STROBE_CYCLES = 4,
   parameter int unsigned READY_TIMEOUT = 1000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] req_addr,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 done,
   output logic                 timeout_err,
   output logic                 busy,
   input  logic                 ms6205_ready,
   output logic [7:0]           ms6205_address,
   output logic [7:0]           ms6205_data,
   output logic                 ms6205_write_addr,
   output logic                 ms6205_write_data
);

   localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned MAX_PH  = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
   localparam int unsigned MAX_CNT = (MAX_PH > READY_TIMEOUT) ? MAX_PH : READY_TIMEOUT;
   localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

   typedef enum logic [3:0] {
      IDLE, WAIT_A, ADDR_SETUP, ADDR_STB, WAIT_D, DATA_SETUP, DATA_STB, DONE, ABORT
   } state_t;

   state_t               state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [IDX_W-1:0]     rr_last, rr_n;
   logic [7:0]           lat_addr, lat_addr_n, lat_data, lat_data_n;
   logic [7:0]           address_n, data_n;
   logic [NUM_REQ-1:0]   grant_n;
   logic                 rdy_m, rdy_s;
   logic                 win_found;
   logic [IDX_W-1:0]     win_idx, cand;

   // Two-flop synchronizer for the asynchronous ready line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_m <= 1'b0;
         rdy_s <= 1'b0;
      end else begin
         rdy_m <= ms6205_ready;
         rdy_s <= rdy_m;
      end
   end

   // Round-robin search starting just after the last winner
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = IDX_W'((32'(rr_last) + k + 32'd1) % NUM_REQ);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Next-state and next-register logic
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      rr_n       = rr_last;
      lat_addr_n = lat_addr;
      lat_data_n = lat_data;
      grant_n    = grant;
      address_n  = ms6205_address;
      data_n     = ms6205_data;
      unique case (state)
         IDLE: begin
            if (win_found) begin
               rr_n       = win_idx;
               lat_addr_n = req_addr[{win_idx, 3'b000} +: 8];
               lat_data_n = req_data[{win_idx, 3'b000} +: 8];
               grant_n    = NUM_REQ'(1) << win_idx;
               cnt_n      = '0;
               state_n    = WAIT_A;
            end
         end
         WAIT_A, WAIT_D: begin
            if (rdy_s) begin
               cnt_n = '0;
               if (state == WAIT_A) begin
                  address_n = lat_addr;
                  state_n   = ADDR_SETUP;
               end else begin
                  data_n  = lat_data;
                  state_n = DATA_SETUP;
               end
            end else if (cnt == CNT_W'(READY_TIMEOUT - 1)) begin
               cnt_n   = '0;
               state_n = ABORT;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         ADDR_SETUP, DATA_SETUP: begin
            if (cnt == CNT_W'(SETUP_CYCLES - 1)) begin
               cnt_n   = '0;
               state_n = (state == ADDR_SETUP) ? ADDR_STB : DATA_STB;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         ADDR_STB, DATA_STB: begin
            if (cnt == CNT_W'(STROBE_CYCLES - 1)) begin
               cnt_n   = '0;
               state_n = (state == ADDR_STB) ? WAIT_D : DONE;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         DONE, ABORT: begin
            grant_n = '0;
            state_n = IDLE;
         end
         default: begin
            grant_n = '0;
            state_n = IDLE;
         end
      endcase
   end

   // State register; outputs registered from the next state so they align with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= IDLE;
         cnt               <= '0;
         rr_last           <= IDX_W'(NUM_REQ - 1);
         lat_addr          <= '0;
         lat_data          <= '0;
         grant             <= '0;
         done              <= 1'b0;
         timeout_err       <= 1'b0;
         busy              <= 1'b0;
         ms6205_address    <= '0;
         ms6205_data       <= '0;
         ms6205_write_addr <= 1'b0;
         ms6205_write_data <= 1'b0;
      end else begin
         state             <= state_n;
         cnt               <= cnt_n;
         rr_last           <= rr_n;
         lat_addr          <= lat_addr_n;
         lat_data          <= lat_data_n;
         grant             <= grant_n;
         done              <= (state_n == DONE) || (state_n == ABORT);
         timeout_err       <= (state_n == ABORT);
         busy              <= (state_n != IDLE);
         ms6205_address    <= address_n;
         ms6205_data       <= data_n;
         ms6205_write_addr <= (state_n == ADDR_STB);
         ms6205_write_data <= (state_n == DATA_STB);
      end
   end

endmodule

// File: tb/tb_ms6205_bus_arbiter.sv
// Directed self-checking bench for ms6205_bus_arbiter.
module tb_ms6205_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  req;
   logic [23:0] req_addr, req_data;
   logic [2:0]  grant;
   logic        done, timeout_err, busy, ready;
   logic [7:0]  address, data;
   logic        write_addr, write_data;

   int checks = 0;
   int errors = 0;
   int n, m, c;
   logic wd_seen, wa_seen;
   logic [2:0] seq [4];

   ms6205_bus_arbiter #(
      .NUM_REQ(3), .SETUP_CYCLES(2), .STROBE_CYCLES(4), .READY_TIMEOUT(1000)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_data(req_data),
      .grant(grant), .done(done), .timeout_err(timeout_err), .busy(busy),
      .ms6205_ready(ready), .ms6205_address(address), .ms6205_data(data),
      .ms6205_write_addr(write_addr), .ms6205_write_data(write_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; req = '0; req_addr = '0; req_data = '0; ready = 1'b0;
      tick(); tick();
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_tmo", 32'(timeout_err), 32'd0);
      check("rst_wa", 32'(write_addr), 32'd0);
      check("rst_wd", 32'(write_data), 32'd0);
      check("rst_addr", 32'(address), 32'd0);
      check("rst_data", 32'(data), 32'd0);
      rst_n = 1'b1; ready = 1'b1;
      tick(); tick(); tick();

      // single request with nominal timing; payload changed after grant
      req = 3'b001; req_addr = {8'hA2, 8'hA1, 8'h12}; req_data = {8'hB2, 8'hB1, 8'h34};
      for (int cy = 1; cy <= 16; cy++) begin
         tick();
         if (cy == 1) req = 3'b000;
         if (cy == 2) req_data[7:0] = 8'hFF;
         check($sformatf("t1_grant_c%0d", cy), 32'(grant), (cy <= 15) ? 32'd1 : 32'd0);
         check($sformatf("t1_busy_c%0d", cy), 32'(busy), 32'(cy <= 15));
         check($sformatf("t1_wa_c%0d", cy), 32'(write_addr), 32'(cy >= 4 && cy <= 7));
         check($sformatf("t1_wd_c%0d", cy), 32'(write_data), 32'(cy >= 11 && cy <= 14));
         check($sformatf("t1_done_c%0d", cy), 32'(done), 32'(cy == 15));
         check($sformatf("t1_tmo_c%0d", cy), 32'(timeout_err), 32'd0);
         if (cy >= 4 && cy <= 7) check($sformatf("t1_addr_c%0d", cy), 32'(address), 32'h12);
         if (cy >= 11) check($sformatf("t1_data_c%0d", cy), 32'(data), 32'h34);
      end

      // reset so the round-robin pointer restarts at requester 0
      rst_n = 1'b0; tick(); rst_n = 1'b1; tick(); tick(); tick();

      // round-robin with all three requesting continuously
      seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b001;
      req = 3'b111;
      tick();
      for (int g = 0; g < 4; g++) begin
         check($sformatf("t2_grant_%0d", g), 32'(grant), 32'(seq[g]));
         n = 0;
         while (grant == seq[g] && n < 40) begin
            n++;
            tick();
         end
         check($sformatf("t2_len_%0d", g), 32'(n), 32'd15);
         check($sformatf("t2_gap_grant_%0d", g), 32'(grant), 32'd0);
         check($sformatf("t2_gap_busy_%0d", g), 32'(busy), 32'd0);
         if (g == 3) req = 3'b000;
         tick();
      end

      // ready stall: nothing strobes until ready arrives through the synchronizer
      ready = 1'b0; tick(); tick(); tick();
      req = 3'b010;
      tick();
      check("t3_grant", 32'(grant), 32'b010);
      req = 3'b000;
      wa_seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (write_addr || write_data) wa_seen = 1'b1;
      end
      check("t3_no_strobe", 32'(wa_seen), 32'd0);
      ready = 1'b1;
      n = 0;
      while (!write_addr && n < 20) begin
         tick();
         n++;
      end
      check("t3_wa_delay", 32'(n), 32'd5);
      m = 0;
      while (!done && m < 30) begin
         tick();
         m++;
      end
      check("t3_done_offset", 32'(m), 32'd11);
      check("t3_tmo", 32'(timeout_err), 32'd0);
      check("t3_grant_at_done", 32'(grant), 32'b010);
      tick();

      // timeout in the data wait, then the other pending requester is served
      req = 3'b101;
      tick();
      check("t4_grant", 32'(grant), 32'b100);
      req = 3'b001;
      tick(); tick(); tick();
      check("t4_wa_c4", 32'(write_addr), 32'd1);
      ready = 1'b0;
      c = 4;
      wd_seen = 1'b0;
      while (!done && c < 1200) begin
         tick();
         c++;
         if (write_data) wd_seen = 1'b1;
      end
      check("t4_done_cycle", 32'(c), 32'd1008);
      check("t4_tmo", 32'(timeout_err), 32'd1);
      check("t4_no_wd", 32'(wd_seen), 32'd0);
      ready = 1'b1;
      tick();
      check("t4_gap_grant", 32'(grant), 32'd0);
      check("t4_gap_done", 32'(done), 32'd0);
      check("t4_gap_tmo", 32'(timeout_err), 32'd0);
      tick();
      check("t4_next_grant", 32'(grant), 32'b001);
      req = 3'b000;
      n = 0;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      check("t4_next_done", 32'(done), 32'd1);
      check("t4_next_tmo", 32'(timeout_err), 32'd0);
      tick();

      // asynchronous reset during the address strobe
      req = 3'b010;
      tick();
      check("t5_grant", 32'(grant), 32'b010);
      req = 3'b000;
      tick(); tick(); tick(); tick();
      check("t5_wa_before", 32'(write_addr), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_wa_async", 32'(write_addr), 32'd0);
      check("t5_grant_async", 32'(grant), 32'd0);
      check("t5_busy_async", 32'(busy), 32'd0);
      check("t5_done_async", 32'(done), 32'd0);
      tick();
      check("t5_done_rst", 32'(done), 32'd0);
      rst_n = 1'b1;
      req = 3'b110;
      tick();
      check("t5_grant_after", 32'(grant), 32'b010);
      req = 3'b000;
      n = 0;
      while (!done && n < 60) begin
         tick();
         n++;
      end
      check("t5_final_done", 32'(done), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
